// File: rtl/paddle_control.sv
// Paddle position control: synchronizes and debounces four player buttons, then
// steps each paddle's top edge once per video frame, clamped to the active area.
module paddle_control #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STEP            = 4,
    parameter int BAR_H           = 90,
    parameter int SCREEN_H        = 480,
    parameter int INIT_Y          = 195
) (
    input  logic       clk_in,
    input  logic       i_rst,
    input  logic [9:0] o_x,
    input  logic [8:0] o_y,
    input  logic       btn_up1_n,
    input  logic       btn_dn1_n,
    input  logic       btn_up2_n,
    input  logic       btn_dn2_n,
    output logic [8:0] pos_yBarra1,
    output logic [8:0] pos_yBarra2,
    output logic       frame_tick
);

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]  STEP_W   = 10'(STEP);
    localparam logic [9:0]  YMAX     = 10'(SCREEN_H - BAR_H);
    localparam logic [8:0]  INIT_W   = 9'(INIT_Y);

    // Button index: 0 = up1, 1 = dn1, 2 = up2, 3 = dn2. All levels active-low.
    logic [3:0]  raw_n;
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  stable_q, stable_d;
    logic [15:0] cnt_q [4];
    logic [15:0] cnt_d [4];
    logic        hit, hit_d_q, hit_d_d;
    logic [8:0]  pos1_q, pos1_d;
    logic [8:0]  pos2_q, pos2_d;

    assign raw_n = {btn_dn2_n, btn_up2_n, btn_dn1_n, btn_up1_n};

    // Widened to 10 bits so y + STEP cannot wrap before the clamp compares it.
    function automatic logic [8:0] next_y(input logic [8:0] y, input logic up, input logic dn);
        logic [9:0] y_w;
        logic [9:0] r;
        y_w = {1'b0, y};
        r   = y_w;
        if (up && !dn) begin
            r = (y_w >= STEP_W) ? y_w - STEP_W : 10'd0;
        end else if (dn && !up) begin
            r = (y_w + STEP_W >= YMAX) ? YMAX : y_w + STEP_W;
        end
        return r[8:0];
    endfunction

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        sync1_d  = raw_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (sync2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == DEB_LAST) begin
                stable_d[k] = sync2_q[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end

        hit        = (o_x == 10'd639) && (o_y == 9'd479);
        hit_d_d    = hit;
        frame_tick = hit && !hit_d_q && !i_rst;

        pos1_d = pos1_q;
        pos2_d = pos2_q;
        if (frame_tick) begin
            pos1_d = next_y(pos1_q, ~stable_q[0], ~stable_q[1]);
            pos2_d = next_y(pos2_q, ~stable_q[2], ~stable_q[3]);
        end
    end

    // NOTE: state is updated with non-blocking assignments only; the debounce
    // counters are reset too, so a partial count never survives i_rst.
    always_ff @(posedge clk_in) begin
        if (i_rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
            hit_d_q  <= 1'b0;
            pos1_q   <= INIT_W;
            pos2_q   <= INIT_W;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            hit_d_q  <= hit_d_d;
            pos1_q   <= pos1_d;
            pos2_q   <= pos2_d;
        end
    end

    assign pos_yBarra1 = pos1_q;
    assign pos_yBarra2 = pos2_q;

endmodule

// File: tb/tb_paddle_control.sv
// Self-checking bench for paddle_control: a cycle-level behavioural model is
// compared every cycle, plus hand-computed literal expectations at key points.
module tb_paddle_control;

    localparam int DEB    = 16;
    localparam int STEP   = 4;
    localparam int YMAX   = 390;
    localparam int INIT_Y = 195;

    logic       clk_in = 1'b0;
    logic       i_rst  = 1'b1;
    logic [9:0] o_x    = '0;
    logic [8:0] o_y    = '0;
    logic       btn_up1_n = 1'b1;
    logic       btn_dn1_n = 1'b1;
    logic       btn_up2_n = 1'b1;
    logic       btn_dn2_n = 1'b1;
    logic [8:0] pos_yBarra1;
    logic [8:0] pos_yBarra2;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    paddle_control #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk_in      (clk_in),
        .i_rst       (i_rst),
        .o_x         (o_x),
        .o_y         (o_y),
        .btn_up1_n   (btn_up1_n),
        .btn_dn1_n   (btn_dn1_n),
        .btn_up2_n   (btn_up2_n),
        .btn_dn2_n   (btn_dn2_n),
        .pos_yBarra1 (pos_yBarra1),
        .pos_yBarra2 (pos_yBarra2),
        .frame_tick  (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Debounce is expressed as "the synced level has held a
    // value different from the accepted level for DEB consecutive cycles".
    int       m_pos [2] = '{INIT_Y, INIT_Y};
    bit       m_prev_hit = 1'b0;
    bit [3:0] m_s1   = 4'hF;
    bit [3:0] m_s2   = 4'hF;
    bit [3:0] m_stab = 4'hF;
    int       m_run [4] = '{1, 1, 1, 1};

    function automatic bit hit_now();
        return (o_x == 10'd639) && (o_y == 9'd479);
    endfunction

    always @(posedge clk_in) begin
        bit [3:0] raw;
        bit up, dn;
        raw = {btn_dn2_n, btn_up2_n, btn_dn1_n, btn_up1_n};
        if (i_rst) begin
            m_pos[0] = INIT_Y; m_pos[1] = INIT_Y;
            m_prev_hit = 1'b0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_stab = 4'hF;
            for (int k = 0; k < 4; k++) m_run[k] = 1;
        end else begin
            if (hit_now() && !m_prev_hit) begin
                for (int p = 0; p < 2; p++) begin
                    up = !m_stab[2*p];
                    dn = !m_stab[2*p+1];
                    if (up && !dn)      m_pos[p] = (m_pos[p] - STEP < 0) ? 0 : m_pos[p] - STEP;
                    else if (dn && !up) m_pos[p] = (m_pos[p] + STEP > YMAX) ? YMAX : m_pos[p] + STEP;
                end
            end
            m_prev_hit = hit_now();
            for (int k = 0; k < 4; k++) begin
                if (m_s2[k] != m_stab[k] && m_run[k] >= DEB) m_stab[k] = m_s2[k];
                if (m_s1[k] == m_s2[k]) m_run[k]++; else m_run[k] = 1;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    always @(negedge clk_in) begin
        check("pos1_model", pos_yBarra1, m_pos[0]);
        check("pos2_model", pos_yBarra2, m_pos[1]);
        check("tick_model", frame_tick, (hit_now() && !m_prev_hit && !i_rst) ? 1 : 0);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic frame();
        o_x = 10'd639; o_y = 9'd479;
        cyc(1);
        o_x = '0; o_y = '0;
        cyc(3);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic at_negedge();
        @(negedge clk_in);
        #1;
    endtask

    int n_ticks;

    initial begin
        // Reset held 3 cycles.
        i_rst = 1'b1;
        cyc(3);
        at_negedge();
        check("reset_pos1", pos_yBarra1, 195);
        check("reset_pos2", pos_yBarra2, 195);
        check("reset_tick", frame_tick, 0);
        i_rst = 1'b0;
        cyc(1);
        frames(5);
        at_negedge();
        check("idle_pos1", pos_yBarra1, 195);

        // 10-cycle glitch is rejected.
        btn_up1_n = 1'b0;
        cyc(10);
        btn_up1_n = 1'b1;
        frames(3);
        at_negedge();
        check("glitch_pos1", pos_yBarra1, 195);

        // Held 20 cycles before a frame: one step up.
        btn_up1_n = 1'b0;
        cyc(20);
        frame();
        at_negedge();
        check("first_step_pos1", pos_yBarra1, 191);

        // Top clamp: 191 -> ... -> 3 -> 0, then holds at 0.
        frames(60);
        at_negedge();
        check("clamp_top_pos1", pos_yBarra1, 0);

        // Bottom clamp on player 2.
        btn_up1_n = 1'b1;
        btn_dn2_n = 1'b0;
        cyc(20);
        frames(60);
        at_negedge();
        check("clamp_bot_pos2", pos_yBarra2, 390);
        check("clamp_bot_pos1", pos_yBarra1, 0);

        // Hit held 8 cycles with down held: one tick, one step.
        btn_dn2_n = 1'b1;
        btn_dn1_n = 1'b0;
        cyc(20);
        n_ticks = 0;
        o_x = 10'd639; o_y = 9'd479;
        repeat (8) begin
            @(negedge clk_in);
            if (frame_tick) n_ticks++;
        end
        @(posedge clk_in);
        #1;
        o_x = '0; o_y = '0;
        cyc(2);
        check("tick_count", n_ticks, 1);
        at_negedge();
        check("single_step_pos1", pos_yBarra1, 4);

        // Both keys on player 1 hold while player 2 steps down.
        i_rst = 1'b1;
        cyc(3);
        i_rst = 1'b0;
        btn_up1_n = 1'b0; btn_dn1_n = 1'b0; btn_dn2_n = 1'b0;
        cyc(20);
        frame();
        at_negedge();
        check("both_keys_pos1", pos_yBarra1, 195);
        check("down_p2_pos2", pos_yBarra2, 199);

        // Bring player 1 to 100: up to 0, then 25 steps down.
        btn_dn1_n = 1'b1; btn_dn2_n = 1'b1;
        cyc(20);
        frames(50);
        btn_up1_n = 1'b1; btn_dn1_n = 1'b0;
        cyc(20);
        frames(25);
        at_negedge();
        check("reach_100_pos1", pos_yBarra1, 100);

        // Reset mid-debounce, coinciding with a frame hit: reset wins.
        btn_dn1_n = 1'b1;
        cyc(20);
        btn_dn1_n = 1'b0;
        cyc(8);
        i_rst = 1'b1;
        o_x = 10'd639; o_y = 9'd479;
        cyc(1);
        i_rst = 1'b0;
        o_x = '0; o_y = '0;
        at_negedge();
        check("midreset_pos1", pos_yBarra1, 195);
        cyc(9);
        frame();
        at_negedge();
        check("requalify_hold_pos1", pos_yBarra1, 195);
        cyc(10);
        frame();
        at_negedge();
        check("requalify_step_pos1", pos_yBarra1, 199);

        btn_dn1_n = 1'b1;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paddle_control.md
# paddle_control

Upstream stage of the ball renderer: converts the four raw player push-buttons into the two paddle top-edge coordinates `pos_yBarra1` / `pos_yBarra2` that the ball/collision logic consumes. Buttons are synchronized, debounced and applied once per video frame, so paddle motion is locked to the same end-of-frame instant at which the ball position advances. Positions are clamped so a 90-line paddle never leaves the 480-line active area.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 50000: consecutive stable `clk_in` cycles required to accept a button change; valid range 1..65535; counter is 16 bits.
- `STEP`, 4: lines moved per frame while a direction is held.
- `BAR_H`, 90: paddle height in lines.
- `SCREEN_H`, 480: active lines.
- `INIT_Y`, 195: paddle top after reset (centred).

Ports:
- `clk_in`  in  1  base clock from the board; all logic is on its rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `o_x`  in  10  current pixel x from the VGA timing generator.
- `o_y`  in  9  current pixel y from the VGA timing generator.
- `btn_up1_n`, `btn_dn1_n`  in  1 each  player 1 up/down keys, raw, asynchronous, active-low.
- `btn_up2_n`, `btn_dn2_n`  in  1 each  player 2 up/down keys, raw, asynchronous, active-low.
- `pos_yBarra1`  out  9  player 1 paddle top y, registered.
- `pos_yBarra2`  out  9  player 2 paddle top y, registered.
- `frame_tick`  out  1  one-cycle pulse marking the cycle where positions are updated; for debug and other stages.

## Operation

- Synchronizer: each raw button passes through two flops. Reset value is 1, meaning released.
- Debouncer: one instance per button. It holds a stable level `s` (reset 1) and a 16-bit counter `c` (reset 0).
  - If the synced level equals `s`, then `c <= 0`.
  - Otherwise `c` increments. When `c == DEBOUNCE_CYCLES-1` and the level still differs, `s` takes the synced level and `c` clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `s`.
- Pressed signals: `up_k = ~s_up_k`, `dn_k = ~s_dn_k`.
- Frame detect: `hit = (o_x == 639) && (o_y == 479)`. Register `hit_d` (reset 0). `frame_tick = hit && !hit_d`. This gives exactly one tick per frame even if `o_x` holds 639 for several `clk_in` cycles.
- Paddle update on a `frame_tick` cycle, per paddle independently, with `YMAX = SCREEN_H - BAR_H` (390 at default):
  - Up only: `y <= (y >= STEP) ? y - STEP : 0`.
  - Down only: `y <= (y + STEP >= YMAX) ? YMAX : y + STEP`.
  - Both pressed or neither pressed: hold.
  - Arithmetic uses 10-bit intermediates so `y + STEP` cannot wrap.
- Outside `frame_tick` cycles, positions hold.

## Timing

- Reset values: `pos_yBarra1 = pos_yBarra2 = INIT_Y` (195), `frame_tick = 0`. All debounced levels released, counters 0, `hit_d = 0`, synchronizer flops 1.
- `i_rst` asserted in the middle of a debounce period discards the partial count. A button held across reset must re-qualify for the full `DEBOUNCE_CYCLES` after release of `i_rst`.
- Raw press to debounced `s` change: 2 sync cycles + `DEBOUNCE_CYCLES` cycles.
- Position change is visible on the rising edge that ends the first cycle where `hit` is 1.
  - The ball stage samples the old positions on that same edge.
  - New positions are in effect for the whole of the next frame.
- Press and release within the same frame: only the level present on the `frame_tick` cycle matters.
- `i_rst` and `frame_tick` in the same cycle: reset wins.

## Test plan

- Reset: hold `i_rst` 3 cycles -> `pos_yBarra1 = pos_yBarra2 = 195`, `frame_tick = 0`. With no buttons pressed for 5 frames, positions stay 195.
- Debounce (`DEBOUNCE_CYCLES = 16`): pulse `btn_up1_n` low for 10 cycles, then run 3 frames -> `pos_yBarra1` stays 195. Hold it low for 20 cycles before a frame -> `pos_yBarra1 = 191` after that frame's tick.
- Clamp top: hold `btn_up1_n` low for 60 frames -> value sequence 195, 191, ..., 3, then 0 and holds 0 with no wrap to 508. Clamp bottom: hold `btn_dn2_n` for 60 frames -> reaches 390 and holds.
- Frame tick uniqueness: drive `o_x = 639`, `o_y = 479` for 8 consecutive cycles with down held -> exactly one `frame_tick` pulse and one step of +4.
- Both keys on player 1 while player 2 presses down -> `pos_yBarra1` holds, `pos_yBarra2` steps +4 on the same tick.
- Reset mid-operation: with player 1 at 100 and the down key mid-debounce, assert `i_rst` for 1 cycle -> 195, and the next step is delayed until a full re-qualification.
